baccarat_ctrl: RTL

Sequencing controller for the baccarat card datapath. It steps through the deal one card per `slow_clock` cycle and drives the six card-register load strobes. It applies the player and banker third-card rules using the datapath's running scores and the player's third card. When the hand completes, it drives the win lights.

---
 rtl/baccarat_pkg.sv | 24 ++
 rtl/banker_draw_rule.sv | 26 ++
 rtl/baccarat_ctrl.sv | 102 ++++++++++
 3 files changed

// File: rtl/baccarat_pkg.sv
// Shared types and constants for the baccarat sequencing controller.
// Optional build macro used by the top: BACCARAT_CARD_COUNT_EN.
package baccarat_pkg;

  typedef enum logic [2:0] {
    S_P1   = 3'd0,
    S_D1   = 3'd1,
    S_P2   = 3'd2,
    S_D2   = 3'd3,
    S_P3   = 3'd4,
    S_D3   = 3'd5,
    S_DONE = 3'd6
  } deal_state_t;

  localparam logic [3:0] NATURAL_MIN = 4'd8;
  localparam logic [3:0] DRAW_MAX    = 4'd5;
  localparam logic [2:0] MAX_CARDS   = 3'd6;

  // Face cards and tens count as zero.
  function automatic logic [3:0] card_value(input logic [3:0] rank);
    return (rank <= 4'd9) ? rank : 4'd0;
  endfunction

endpackage

// File: rtl/banker_draw_rule.sv
// Banker third-card table: decides whether the banker draws once the
// player has taken a third card.
module banker_draw_rule
  import baccarat_pkg::*;
(
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       draw
);

  logic [3:0] v;

  always_comb begin
    v    = card_value(pcard3);
    draw = 1'b0;
    case (dscore)
      4'd0, 4'd1, 4'd2: draw = 1'b1;
      4'd3:             draw = (v != 4'd8);
      4'd4:             draw = (v >= 4'd2) && (v <= 4'd7);
      4'd5:             draw = (v >= 4'd4) && (v <= 4'd7);
      4'd6:             draw = (v >= 4'd6) && (v <= 4'd7);
      default:          draw = 1'b0;
    endcase
  end

endmodule

// File: rtl/baccarat_ctrl.sv
// Moore sequencer for one baccarat hand: one card per slow_clock cycle,
// third-card rules, win lights. BACCARAT_CARD_COUNT_EN adds cards_dealt.
module baccarat_ctrl
  import baccarat_pkg::*;
(
  input  logic       slow_clock,
  input  logic       resetb,
  input  logic [3:0] pscore,
  input  logic [3:0] dscore,
  input  logic [3:0] pcard3,
  output logic       load_pcard1,
  output logic       load_pcard2,
  output logic       load_pcard3,
  output logic       load_dcard1,
  output logic       load_dcard2,
  output logic       load_dcard3,
  output logic       player_win_light,
  output logic       dealer_win_light,
  output logic       done
`ifdef BACCARAT_CARD_COUNT_EN
  ,output logic [2:0] cards_dealt
`endif
);

  deal_state_t state, state_nx;
  logic        banker_draw;
  logic        natural;

  banker_draw_rule u_rule (
    .dscore (dscore),
    .pcard3 (pcard3),
    .draw   (banker_draw)
  );

  assign natural = (pscore >= NATURAL_MIN) || (dscore >= NATURAL_MIN);

  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb) state <= S_P1;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = S_P1;
    case (state)
      S_P1: state_nx = S_D1;
      S_D1: state_nx = S_P2;
      S_P2: state_nx = S_D2;
      S_D2: begin
        if (natural)                state_nx = S_DONE;
        else if (pscore <= DRAW_MAX) state_nx = S_P3;
        else if (dscore <= DRAW_MAX) state_nx = S_D3;
        else                        state_nx = S_DONE;
      end
      S_P3:    state_nx = banker_draw ? S_D3 : S_DONE;
      S_D3:    state_nx = S_DONE;
      S_DONE:  state_nx = S_DONE;
      default: state_nx = S_P1;  // unreachable encoding recovers
    endcase
  end

  always_comb begin
    load_pcard1      = 1'b0;
    load_pcard2      = 1'b0;
    load_pcard3      = 1'b0;
    load_dcard1      = 1'b0;
    load_dcard2      = 1'b0;
    load_dcard3      = 1'b0;
    player_win_light = 1'b0;
    dealer_win_light = 1'b0;
    done             = 1'b0;
    case (state)
      S_P1: load_pcard1 = 1'b1;
      S_D1: load_dcard1 = 1'b1;
      S_P2: load_pcard2 = 1'b1;
      S_D2: load_dcard2 = 1'b1;
      S_P3: load_pcard3 = 1'b1;
      S_D3: load_dcard3 = 1'b1;
      S_DONE: begin
        done             = 1'b1;
        player_win_light = (pscore >= dscore);
        dealer_win_light = (dscore >= pscore);
      end
      default: ;
    endcase
  end

`ifdef BACCARAT_CARD_COUNT_EN
  logic strobe_any;

  assign strobe_any = load_pcard1 | load_pcard2 | load_pcard3 |
                      load_dcard1 | load_dcard2 | load_dcard3;

  // Every strobe state is left on the next edge, so count strobe cycles.
  always_ff @(posedge slow_clock or negedge resetb) begin
    if (!resetb)
      cards_dealt <= 3'd0;
    else if (strobe_any && (cards_dealt != MAX_CARDS))
      cards_dealt <= cards_dealt + 3'd1;
  end
`endif

endmodule
